// File: rtl/key_sched_pkg.sv
// Shared definitions for the key scheduler and related arbiters.
// Holds the default key count, event polarity constants, the event
// record type and the lowest-set-index helper.
package key_sched_pkg;

    localparam int NUM_KEYS_DEF = 8;
    // Widest key index supported (16 keys).
    localparam int KEY_W_MAX    = 4;

    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    typedef struct packed {
        logic [KEY_W_MAX-1:0] key;
        logic                 press;
    } key_evt_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [KEY_W_MAX-1:0] lowest_set(input logic [15:0] v);
        logic [KEY_W_MAX-1:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r = KEY_W_MAX'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_note_scheduler_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching upward from i_ptr with wrap-around. Generic so other
// arbiters can reuse it.
module rr_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_gnt_idx,
    output logic         o_any
);

    int         w_idx;
    logic [W-1:0] w_sel;

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_idx     = 0;
        w_sel     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_sel = W'(w_idx);
            if (!o_any && i_req[w_sel]) begin
                o_any     = 1'b1;
                o_gnt_idx = w_sel;
            end
        end
    end

endmodule

// File: rtl/key_note_scheduler.sv
// Key note scheduler: serializes key press/release changes into a
// valid/ready event stream (round-robin, coalescing) and tracks the
// last-pressed "current note".
// Optional macro KEY_SCHED_SYNC_EN: adds a two-flop synchronizer ahead
// of the key capture register (two extra edges of latency).
module key_note_scheduler
    import key_sched_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int KEY_W    = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] i_key_in,
    output logic                o_evt_valid,
    input  logic                i_evt_ready,
    output logic [KEY_W-1:0]    o_evt_key,
    output logic                o_evt_press,
    output logic                o_note_valid,
    output logic [KEY_W-1:0]    o_note_key
);

    logic [NUM_KEYS-1:0] r_key_q;
    logic [NUM_KEYS-1:0] r_rep;
    logic [KEY_W-1:0]    r_rr_ptr;
    logic                r_evt_valid;
    logic [KEY_W-1:0]    r_evt_key;
    logic                r_evt_press;
    logic                r_note_valid;
    logic [KEY_W-1:0]    r_note_key;

    logic [NUM_KEYS-1:0] w_pend;
    logic [KEY_W-1:0]    w_gnt;
    logic                w_any;
    logic                w_free;
    logic                w_load;
    logic                w_gnt_lvl;
    logic [NUM_KEYS-1:0] w_rep_next;
    logic [15:0]         w_rep_ext;
    logic [KEY_W-1:0]    w_ptr_next;
    logic [KEY_W-1:0]    w_note_key_next;

`ifdef KEY_SCHED_SYNC_EN
    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;

    // Two-flop synchronizer, then the capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_key_q <= '0;
        end else begin
            r_sync1 <= i_key_in;
            r_sync2 <= r_sync1;
            r_key_q <= r_sync2;
        end
    end
`else
    // Single capture register for the already-debounced key levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_q <= '0;
        end else begin
            r_key_q <= i_key_in;
        end
    end
`endif

    // A key is pending while its level differs from what was last
    // reported; even toggle counts cancel out here naturally.
    assign w_pend = r_key_q ^ r_rep;

    rr_pick #(
        .N (NUM_KEYS),
        .W (KEY_W)
    ) u_rr_pick (
        .i_req     (w_pend),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_gnt),
        .o_any     (w_any)
    );

    assign w_free    = !r_evt_valid || i_evt_ready;
    assign w_load    = w_free && w_any;
    assign w_gnt_lvl = r_key_q[w_gnt];

    // Reported-level vector as it will look after loading the grant.
    always_comb begin
        w_rep_next        = r_rep;
        w_rep_next[w_gnt] = w_gnt_lvl;
        w_rep_ext         = '0;
        w_rep_ext[NUM_KEYS-1:0] = w_rep_next;
    end

    // Pointer moves just past the granted key, wrapping at NUM_KEYS.
    always_comb begin
        if (w_gnt == KEY_W'(NUM_KEYS - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_gnt + 1'b1;
        end
    end

    // Last-pressed priority; releasing the sounding key falls back to
    // the lowest key still held.
    always_comb begin
        w_note_key_next = r_note_key;
        if (w_gnt_lvl == EVT_PRESS) begin
            w_note_key_next = w_gnt;
        end else if (w_gnt == r_note_key) begin
            w_note_key_next = KEY_W'(lowest_set(w_rep_ext));
        end
    end

    // Event output register, reported levels and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_key   <= '0;
            r_evt_press <= EVT_RELEASE;
            r_rep       <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_evt_valid <= 1'b1;
            r_evt_key   <= w_gnt;
            r_evt_press <= w_gnt_lvl;
            r_rep       <= w_rep_next;
            r_rr_ptr    <= w_ptr_next;
        end else if (w_free) begin
            r_evt_valid <= 1'b0;
        end
    end

    // Current note updates on the load edge, not on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note_valid <= 1'b0;
            r_note_key   <= '0;
        end else if (w_load) begin
            r_note_valid <= |w_rep_next;
            r_note_key   <= w_note_key_next;
        end
    end

    assign o_evt_valid  = r_evt_valid;
    assign o_evt_key    = r_evt_key;
    assign o_evt_press  = r_evt_press;
    assign o_note_valid = r_note_valid;
    assign o_note_key   = r_note_key;

endmodule

// File: tb/tb_key_note_scheduler.sv
// Directed bench for key_note_scheduler with hand-computed expectations.
module tb_key_note_scheduler;

`ifdef KEY_SCHED_SYNC_EN
    localparam int LAT      = 4;
    localparam int RST_EDGE = 5;
`else
    localparam int LAT      = 2;
    localparam int RST_EDGE = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] key_in;
    logic       evt_ready;
    logic       evt_valid;
    logic [2:0] evt_key;
    logic       evt_press;
    logic       note_valid;
    logic [2:0] note_key;

    int n_vec;
    int n_err;

    key_note_scheduler #(.NUM_KEYS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_key_in     (key_in),
        .o_evt_valid  (evt_valid),
        .i_evt_ready  (evt_ready),
        .o_evt_key    (evt_key),
        .o_evt_press  (evt_press),
        .o_note_valid (note_valid),
        .o_note_key   (note_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        key_in = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    // Apply a key vector with ready=1 and check the single resulting event.
    task automatic key_evt(input logic [7:0] kv, input logic [2:0] ek, input logic ep,
                           input logic env, input logic [2:0] enk);
        key_in = kv;
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            chk("early_valid", 32'(evt_valid), 32'd0);
        end
        tick();
        chk("evt_valid", 32'(evt_valid), 32'd1);
        chk("evt_key", 32'(evt_key), 32'(ek));
        chk("evt_press", 32'(evt_press), 32'(ep));
        chk("note_valid", 32'(note_valid), 32'(env));
        chk("note_key", 32'(note_key), 32'(enk));
        tick();
        chk("idle_valid", 32'(evt_valid), 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        key_in    = 8'h00;
        evt_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_key", 32'(evt_key), 32'd0);
        chk("rst_press", 32'(evt_press), 32'd0);
        chk("rst_note_valid", 32'(note_valid), 32'd0);
        chk("rst_note_key", 32'(note_key), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Quiet bank: nothing happens.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("quiet_valid", 32'(evt_valid), 32'd0);
            chk("quiet_note", 32'(note_valid), 32'd0);
        end

        // Single press of key 2.
        key_evt(8'h04, 3'd2, 1'b1, 1'b1, 3'd2);

        // All keys at once while stalled; round-robin from key 0.
        do_reset();
        evt_ready = 1'b0;
        key_in    = 8'hFF;
        for (int i = 0; i < LAT; i++) tick();
        chk("stall_valid", 32'(evt_valid), 32'd1);
        chk("stall_key", 32'(evt_key), 32'd0);
        chk("stall_press", 32'(evt_press), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", 32'(evt_valid), 32'd1);
            chk("hold_key", 32'(evt_key), 32'd0);
            chk("hold_press", 32'(evt_press), 32'd1);
        end
        evt_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("b2b_valid", 32'(evt_valid), 32'd1);
            chk("b2b_key", 32'(evt_key), 32'(k));
            chk("b2b_press", 32'(evt_press), 32'd1);
        end
        tick();
        chk("b2b_done", 32'(evt_valid), 32'd0);
        chk("b2b_note_key", 32'(note_key), 32'd7);
        chk("b2b_note_valid", 32'(note_valid), 32'd1);

        // Current-note tracking: 3, 5, back to 3, then none.
        do_reset();
        evt_ready = 1'b1;
        key_evt(8'h08, 3'd3, 1'b1, 1'b1, 3'd3);
        key_evt(8'h28, 3'd5, 1'b1, 1'b1, 3'd5);
        key_evt(8'h08, 3'd5, 1'b0, 1'b1, 3'd3);
        key_evt(8'h00, 3'd3, 1'b0, 1'b0, 3'd0);

        // One-cycle pulse on key 6 during a stall is coalesced away.
        evt_ready = 1'b0;
        key_in    = 8'h01;
        for (int i = 0; i < LAT; i++) tick();
        chk("coal_valid", 32'(evt_valid), 32'd1);
        chk("coal_key", 32'(evt_key), 32'd0);
        key_in = 8'h41;
        tick();
        key_in = 8'h01;
        for (int i = 0; i < 4; i++) tick();
        chk("coal_hold_key", 32'(evt_key), 32'd0);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("coal_no_evt", 32'(evt_valid), 32'd0);
        end

        // Reset during a stall drops the event; held key re-reports.
        do_reset();
        evt_ready = 1'b0;
        key_in    = 8'h02;
        for (int i = 0; i < LAT; i++) tick();
        chk("pre_rst_valid", 32'(evt_valid), 32'd1);
        chk("pre_rst_key", 32'(evt_key), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_valid), 32'd0);
        chk("mid_rst_key", 32'(evt_key), 32'd0);
        chk("mid_rst_press", 32'(evt_press), 32'd0);
        chk("mid_rst_nvalid", 32'(note_valid), 32'd0);
        chk("mid_rst_nkey", 32'(note_key), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_e1", 32'(evt_valid), 32'd0);
        for (int i = 0; i < RST_EDGE - 1; i++) tick();
        chk("post_rst_valid", 32'(evt_valid), 32'd1);
        chk("post_rst_key", 32'(evt_key), 32'd1);
        chk("post_rst_press", 32'(evt_press), 32'd1);
        chk("post_rst_note", 32'(note_key), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
